// File: rtl/tx_cmd_arbiter_if.sv
// Command-source / framer bundle for tx_cmd_arbiter.
// Slave side is the arbiter; master side is producers plus framer.
interface tx_cmd_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]     req;
  logic [NREQ*128-1:0] req_data;
  logic [NREQ-1:0]     req_ack;
  logic [NREQ-1:0]     req_done;
  logic                timeout_err;
  logic                busy;
  logic [127:0]        tx_data;
  logic                send_en;
  logic                frm_busy;
  logic                tx_ready;

  modport master (
    output req, req_data, frm_busy, tx_ready,
    input  req_ack, req_done, timeout_err,
    input  busy, tx_data, send_en
  );

  modport slave (
    input  req, req_data, frm_busy, tx_ready,
    output req_ack, req_done, timeout_err,
    output busy, tx_data, send_en
  );
endinterface

// File: rtl/tx_cmd_arbiter.sv
// Round-robin arbiter sharing one 128-bit UART command framer.
// Generates send_en launch pulses with a framer-visible low gap.
module tx_cmd_arbiter #(
  parameter int NREQ      = 4,
  parameter int LAUNCH_TO = 64,
  parameter int GAP_CYC   = 3
) (
  input logic          clk,
  input logic          rst_n,
  tx_cmd_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(LAUNCH_TO + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    GAP
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   own_q, own_d;
  logic [127:0]    txd_q, txd_d;
  logic            send_q, send_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            to_err_q, to_err_d;
  logic [TW-1:0]   to_q, to_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic            found;
  logic [IW-1:0]   pick;

  // First requester at or above rr_q, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[(int'(rr_q) + k) % NREQ]) begin
        found = 1'b1;
        pick  = IW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    own_d    = own_q;
    txd_d    = txd_q;
    send_d   = 1'b0;
    ack_d    = '0;
    done_d   = '0;
    to_err_d = 1'b0;
    to_d     = to_q;
    gap_d    = gap_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = LAUNCH;
          txd_d      = bus.req_data[128*int'(pick) +: 128];
          own_d      = pick;
          ack_d[pick] = 1'b1;
          rr_d       = (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
          to_d       = '0;
          send_d     = 1'b1;
        end
      end
      LAUNCH: begin
        to_d = to_q + 1'b1;
        // frm_busy beats a coincident timeout
        if (bus.frm_busy) begin
          state_d = BUSY;
        end else if (to_q == TW'(LAUNCH_TO - 1)) begin
          state_d  = GAP;
          to_err_d = 1'b1;
          gap_d    = '0;
        end else begin
          send_d = 1'b1;
        end
      end
      BUSY: begin
        if (!bus.frm_busy) begin
          state_d       = GAP;
          done_d[own_q] = 1'b1;
          gap_d         = '0;
        end
      end
      GAP: begin
        // framer only sees send_en low while tx_ready is low
        if (!bus.tx_ready) begin
          if (gap_q == GW'(GAP_CYC - 1)) begin
            state_d = IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        rr_d    = '0;
        own_d   = '0;
        txd_d   = '0;
        to_d    = '0;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      own_q    <= '0;
      txd_q    <= '0;
      send_q   <= 1'b0;
      ack_q    <= '0;
      done_q   <= '0;
      to_err_q <= 1'b0;
      to_q     <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      own_q    <= own_d;
      txd_q    <= txd_d;
      send_q   <= send_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      to_err_q <= to_err_d;
      to_q     <= to_d;
      gap_q    <= gap_d;
    end
  end

  assign bus.req_ack     = ack_q;
  assign bus.req_done    = done_q;
  assign bus.timeout_err = to_err_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.tx_data     = txd_q;
  assign bus.send_en     = send_q;

endmodule

// File: tb/tb_tx_cmd_arbiter.sv
// Directed plus randomized bench for tx_cmd_arbiter.
// Includes a behavioural framer and a grant/ownership reference model.
module tb_tx_cmd_arbiter;

  localparam int NREQ = 4;
  localparam int LTO  = 64;
  localparam int GAPC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_cmd_arbiter_if #(.NREQ(NREQ)) bus ();

  tx_cmd_arbiter #(
    .NREQ(NREQ),
    .LAUNCH_TO(LTO),
    .GAP_CYC(GAPC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int           m_ptr = 0;
  int           m_owner = 0;
  bit           m_out = 1'b0;
  logic         m_prev_busy = 1'b0;
  logic [127:0] m_prev_tx = '0;

  bit fr_en = 1'b1;
  int fr_delay = 3;
  int fr_hold = 200;
  int fr_cnt = 0;
  bit fr_act = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[k]) return k;
    return -1;
  endfunction

  // Reference: arbiter grants only out of idle, owns one frame at a time
  task automatic monitor();
    logic [NREQ-1:0] exp_ack;
    logic [NREQ-1:0] exp_done;
    int w;
    if (!rst_n) begin
      m_ptr = 0;
      m_out = 1'b0;
      m_prev_busy = 1'b0;
      m_prev_tx = '0;
      return;
    end
    exp_ack = '0;
    w = -1;
    if (!m_prev_busy && |bus.req) begin
      w = pick(bus.req, m_ptr);
      exp_ack[w] = 1'b1;
    end
    check("ack_grant", bus.req_ack, exp_ack);
    if (w >= 0) begin
      check("ack_data", bus.tx_data, bus.req_data[128*w +: 128]);
      check("ack_no_overlap", m_out, 0);
      m_out = 1'b1;
      m_owner = w;
      m_ptr = (w + 1) % NREQ;
    end else if (m_prev_busy) begin
      check("tx_hold", bus.tx_data, m_prev_tx);
    end
    if (|bus.req_done) begin
      exp_done = '0;
      exp_done[m_owner] = 1'b1;
      check("done_idx", bus.req_done, exp_done);
      check("done_owned", m_out, 1);
      m_out = 1'b0;
    end
    if (bus.timeout_err) begin
      check("to_owned", m_out, 1);
      m_out = 1'b0;
    end
    m_prev_busy = bus.busy;
    m_prev_tx = bus.tx_data;
  endtask

  task automatic framer();
    if (!rst_n) begin
      bus.frm_busy = 1'b0;
      fr_act = 1'b0;
      fr_cnt = 0;
      return;
    end
    if (!fr_act) begin
      if (bus.send_en && fr_en) begin
        fr_cnt++;
        if (fr_cnt >= fr_delay) begin
          bus.frm_busy = 1'b1;
          fr_act = 1'b1;
          fr_cnt = 0;
        end
      end else begin
        fr_cnt = 0;
      end
    end else begin
      fr_cnt++;
      if (fr_cnt >= fr_hold) begin
        bus.frm_busy = 1'b0;
        fr_act = 1'b0;
        fr_cnt = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
    @(negedge clk);
    framer();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 2000) begin
      tick();
      n++;
    end
    check(tag, bus.busy, 0);
  endtask

  task automatic wait_done(input string tag, input int i);
    int n = 0;
    while (!bus.req_done[i] && n < 1000) begin
      tick();
      n++;
    end
    check(tag, bus.req_done[i], 1);
  endtask

  localparam logic [127:0] D1 =
    128'h00112233_44556677_8899AABB_CCDDEEFF;

  initial begin
    int n;
    int got[$];
    logic [NREQ-1:0] nr;

    bus.req = '0;
    bus.req_data = '0;
    bus.frm_busy = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (3) tick();
    check("rst_ack", bus.req_ack, 0);
    check("rst_done", bus.req_done, 0);
    check("rst_to", bus.timeout_err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_send", bus.send_en, 0);
    check("rst_txd", bus.tx_data, 0);
    rst_n = 1'b1;
    tick();

    // round robin with all requests held
    fr_delay = 2;
    fr_hold = 5;
    for (int i = 0; i < NREQ; i++)
      bus.req_data[128*i +: 128] = {4{32'hA000_0000 + 32'(i)}};
    bus.req = '1;
    n = 0;
    while (got.size() < 5 && n < 500) begin
      tick();
      if (|bus.req_ack) got.push_back(idx_of(bus.req_ack));
      n++;
    end
    bus.req = '0;
    check("rr_count", got.size(), 5);
    for (int k = 0; k < got.size(); k++)
      check("rr_order", got[k], k % NREQ);
    wait_idle("rr_idle");

    // single request, long frame, gap gating
    fr_delay = 3;
    fr_hold = 200;
    bus.req_data[128*1 +: 128] = D1;
    bus.req = 4'b0010;
    tick();
    check("single_ack", bus.req_ack, 4'b0010);
    check("single_send_rise", bus.send_en, 1);
    check("single_txd", bus.tx_data, D1);
    bus.req = '0;
    repeat (2) begin
      tick();
      check("single_send_hold", bus.send_en, 1);
    end
    tick();
    check("single_send_drop", bus.send_en, 0);
    check("single_busy", bus.busy, 1);
    n = 0;
    while (bus.frm_busy && n < 400) begin
      tick();
      check("single_no_early_done", bus.req_done, 0);
      n++;
    end
    check("single_frm_fall", bus.frm_busy, 0);
    tick();
    check("single_done", bus.req_done, 4'b0010);
    check("single_txd_end", bus.tx_data, D1);
    bus.tx_ready = 1'b1;
    repeat (10) begin
      tick();
      check("gap_hold_busy", bus.busy, 1);
      check("gap_hold_send", bus.send_en, 0);
    end
    bus.tx_ready = 1'b0;
    tick();
    check("gap_cnt1", bus.busy, 1);
    tick();
    check("gap_cnt2", bus.busy, 1);
    tick();
    check("gap_release", bus.busy, 0);

    // launch timeout, then normal service
    fr_en = 1'b0;
    bus.req_data[127:0] = {$urandom, $urandom, $urandom, $urandom};
    bus.req = 4'b0001;
    tick();
    check("to_ack", bus.req_ack, 4'b0001);
    bus.req = '0;
    n = 0;
    while (!bus.timeout_err && n < LTO + 20) begin
      tick();
      n++;
    end
    check("to_latency", n, LTO);
    check("to_send_low", bus.send_en, 0);
    check("to_no_done", bus.req_done, 0);
    wait_idle("to_idle");
    fr_en = 1'b1;
    fr_hold = 20;
    bus.req_data[128*3 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    bus.req = 4'b1000;
    tick();
    check("after_to_ack", bus.req_ack, 4'b1000);
    bus.req = '0;
    wait_done("after_to_done", 3);
    wait_idle("after_to_idle");

    // frm_busy rises in the last launch cycle
    fr_delay = LTO;
    fr_hold = 5;
    bus.req = 4'b0100;
    tick();
    check("sim_ack", bus.req_ack, 4'b0100);
    bus.req = '0;
    repeat (LTO - 1) begin
      tick();
      check("sim_no_to_early", bus.timeout_err, 0);
    end
    tick();
    check("sim_no_to", bus.timeout_err, 0);
    check("sim_send_low", bus.send_en, 0);
    check("sim_busy", bus.busy, 1);
    wait_done("sim_done", 2);
    wait_idle("sim_idle");

    // reset during BUSY
    fr_delay = 2;
    fr_hold = 50;
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    n = 0;
    while (!bus.frm_busy && n < 50) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    bus.req = 4'b1100;
    #1;
    check("mid_rst_ack", bus.req_ack, 0);
    check("mid_rst_done", bus.req_done, 0);
    check("mid_rst_to", bus.timeout_err, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_send", bus.send_en, 0);
    check("mid_rst_txd", bus.tx_data, 0);
    tick();
    tick();
    check("mid_rst_nodone", bus.req_done, 0);
    rst_n = 1'b1;
    tick();
    check("rst_first_grant", bus.req_ack, 4'b0100);
    bus.req = bus.req & ~bus.req_ack;

    // random traffic against the reference model
    for (int it = 0; it < 1500; it++) begin
      bus.req = bus.req & ~bus.req_ack;
      if ($urandom % 4 == 0) begin
        nr = NREQ'($urandom);
        for (int i = 0; i < NREQ; i++)
          if (nr[i] && !bus.req[i])
            bus.req_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
        bus.req = bus.req | nr;
      end
      if ($urandom % 16 == 0) bus.req[$urandom % NREQ] = 1'b0;
      bus.tx_ready = ($urandom % 3 == 0);
      if (!fr_act) begin
        fr_delay = $urandom_range(1, 6);
        fr_hold = $urandom_range(1, 12);
      end
      tick();
    end
    bus.req = '0;
    bus.tx_ready = 1'b0;
    wait_idle("drain_idle");
    check("drain_owned", m_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
